alu_operand_stage: RTL

//  Pipeline stage directly upstream of the ALU: selects operand A (rs1/pc) and operand B (rs2/imm),

---
 rtl/alu_operand_stage_pkg.sv | 25 ++
 rtl/alu_opstage_entry.sv | 128 ++++++++++++
 rtl/alu_operand_stage.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/alu_operand_stage_pkg.sv
// ============================================================================
// Module : alu_operand_stage_pkg
// Brief  : Shared ALU select encodings and widths for the operand stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_operand_stage_pkg;

    localparam int ALU_SEL_W = 4;

    localparam logic [ALU_SEL_W-1:0] OP_ADD  = 4'h0;
    localparam logic [ALU_SEL_W-1:0] OP_SUB  = 4'h1;
    localparam logic [ALU_SEL_W-1:0] OP_AND  = 4'h2;
    localparam logic [ALU_SEL_W-1:0] OP_OR   = 4'h3;
    localparam logic [ALU_SEL_W-1:0] OP_XOR  = 4'h4;
    localparam logic [ALU_SEL_W-1:0] OP_SLL  = 4'h5;
    localparam logic [ALU_SEL_W-1:0] OP_SRL  = 4'h6;
    localparam logic [ALU_SEL_W-1:0] OP_SRA  = 4'h7;
    localparam logic [ALU_SEL_W-1:0] OP_SLT  = 4'h8;
    localparam logic [ALU_SEL_W-1:0] OP_SLTU = 4'h9;

endpackage

`default_nettype wire

// File: rtl/alu_opstage_entry.sv
// ============================================================================
// Module : alu_opstage_entry
// Brief  : One storage slot (valid, operands, tags) with optional writeback
//          snoop when ALU_OPSTAGE_FWD_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_opstage_entry
    import alu_operand_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid_d,
    input  logic                 i_load,
    input  logic [XLEN-1:0]      i_a,
    input  logic [XLEN-1:0]      i_b,
    input  logic [ALU_SEL_W-1:0] i_sel,
    input  logic [REG_AW-1:0]    i_rd,
    input  logic                 i_wen,
    input  logic [REG_AW-1:0]    i_rs1_addr,
    input  logic [REG_AW-1:0]    i_rs2_addr,
    input  logic                 i_a_sel,
    input  logic                 i_b_sel,
    input  logic                 i_wb_en,
    input  logic [REG_AW-1:0]    i_wb_rd,
    input  logic [XLEN-1:0]      i_wb_data,
    output logic                 o_valid,
    output logic [XLEN-1:0]      o_a,
    output logic [XLEN-1:0]      o_b,
    output logic [XLEN-1:0]      o_fa,
    output logic [XLEN-1:0]      o_fb,
    output logic [ALU_SEL_W-1:0] o_sel,
    output logic [REG_AW-1:0]    o_rd,
    output logic                 o_wen,
    output logic [REG_AW-1:0]    o_rs1_addr,
    output logic [REG_AW-1:0]    o_rs2_addr,
    output logic                 o_a_sel,
    output logic                 o_b_sel
);

    logic                 r_valid;
    logic [XLEN-1:0]      r_a;
    logic [XLEN-1:0]      r_b;
    logic [ALU_SEL_W-1:0] r_sel;
    logic [REG_AW-1:0]    r_rd;
    logic                 r_wen;
    logic [XLEN-1:0]      w_fa;
    logic [XLEN-1:0]      w_fb;

`ifdef ALU_OPSTAGE_FWD_EN
    logic [REG_AW-1:0] r_rs1_addr;
    logic [REG_AW-1:0] r_rs2_addr;
    logic              r_a_sel;
    logic              r_b_sel;

    // Only register-sourced operands snoop; x0 never forwards.
    assign w_fa = (r_valid && !r_a_sel && i_wb_en && (i_wb_rd == r_rs1_addr) &&
                   (r_rs1_addr != '0)) ? i_wb_data : r_a;
    assign w_fb = (r_valid && !r_b_sel && i_wb_en && (i_wb_rd == r_rs2_addr) &&
                   (r_rs2_addr != '0)) ? i_wb_data : r_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
            r_a_sel    <= 1'b0;
            r_b_sel    <= 1'b0;
        end else if (i_load) begin
            r_rs1_addr <= i_rs1_addr;
            r_rs2_addr <= i_rs2_addr;
            r_a_sel    <= i_a_sel;
            r_b_sel    <= i_b_sel;
        end
    end

    assign o_rs1_addr = r_rs1_addr;
    assign o_rs2_addr = r_rs2_addr;
    assign o_a_sel    = r_a_sel;
    assign o_b_sel    = r_b_sel;
`else
    logic w_unused_snoop;

    assign w_fa           = r_a;
    assign w_fb           = r_b;
    assign o_rs1_addr     = '0;
    assign o_rs2_addr     = '0;
    assign o_a_sel        = 1'b0;
    assign o_b_sel        = 1'b0;
    assign w_unused_snoop = ^{i_rs1_addr, i_rs2_addr, i_a_sel, i_b_sel,
                              i_wb_en, i_wb_rd, i_wb_data};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sel   <= '0;
            r_rd    <= '0;
            r_wen   <= 1'b0;
        end else begin
            r_valid <= i_valid_d;
            r_a     <= i_load ? i_a : w_fa;
            r_b     <= i_load ? i_b : w_fb;
            if (i_load) begin
                r_sel <= i_sel;
                r_rd  <= i_rd;
                r_wen <= i_wen;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_a     = r_a;
    assign o_b     = r_b;
    assign o_fa    = w_fa;
    assign o_fb    = w_fb;
    assign o_sel   = r_sel;
    assign o_rd    = r_rd;
    assign o_wen   = r_wen;

endmodule

`default_nettype wire

// File: rtl/alu_operand_stage.sv
// ============================================================================
// Module : alu_operand_stage
// Brief  : Operand select + 2-entry skid buffer feeding the ALU.
//          Optional writeback forwarding: define ALU_OPSTAGE_FWD_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_AW-1:0]    rs1_addr,
    input  logic [REG_AW-1:0]    rs2_addr,
    input  logic [XLEN-1:0]      rs1_data,
    input  logic [XLEN-1:0]      rs2_data,
    input  logic [XLEN-1:0]      pc,
    input  logic [XLEN-1:0]      imm,
    input  logic                 a_sel,
    input  logic                 b_sel,
    input  logic [ALU_SEL_W-1:0] alu_sel_in,
    input  logic [REG_AW-1:0]    rd_in,
    input  logic                 wen_in,
    input  logic                 wb_en,
    input  logic [REG_AW-1:0]    wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      alu_a,
    output logic [XLEN-1:0]      alu_b,
    output logic [ALU_SEL_W-1:0] alu_sel,
    output logic [REG_AW-1:0]    rd_out,
    output logic                 wen_out
);

    logic                 w_main_v, w_skid_v;
    logic                 w_accept, w_consume;
    logic                 w_main_vd, w_skid_vd;
    logic                 w_main_ld, w_skid_ld, w_main_from_skid;
    logic [XLEN-1:0]      w_rs1_val, w_rs2_val, w_cap_a, w_cap_b;

    logic [XLEN-1:0]      w_skid_fa, w_skid_fb;
    logic [ALU_SEL_W-1:0] w_skid_sel;
    logic [REG_AW-1:0]    w_skid_rd, w_skid_rs1, w_skid_rs2;
    logic                 w_skid_wen, w_skid_asel, w_skid_bsel;
    logic [XLEN-1:0]      w_skid_unused_a, w_skid_unused_b;

    logic [XLEN-1:0]      w_main_unused_fa, w_main_unused_fb;
    logic [REG_AW-1:0]    w_main_unused_rs1, w_main_unused_rs2;
    logic                 w_main_unused_asel, w_main_unused_bsel;

`ifdef ALU_OPSTAGE_FWD_EN
    assign w_rs1_val = (wb_en && (wb_rd == rs1_addr) && (rs1_addr != '0)) ? wb_data : rs1_data;
    assign w_rs2_val = (wb_en && (wb_rd == rs2_addr) && (rs2_addr != '0)) ? wb_data : rs2_data;
`else
    assign w_rs1_val = rs1_data;
    assign w_rs2_val = rs2_data;
`endif

    assign w_cap_a   = a_sel ? pc  : w_rs1_val;
    assign w_cap_b   = b_sel ? imm : w_rs2_val;

    assign in_ready  = !w_skid_v;
    assign out_valid = w_main_v;
    assign w_accept  = in_valid && in_ready;
    assign w_consume = w_main_v && out_ready;

    // Main refills from skid only when FULL drains; otherwise new ops go to main
    // unless main is held by a stalled op, in which case they park in skid.
    always_comb begin
        w_main_vd        = w_main_v;
        w_skid_vd        = w_skid_v;
        w_main_ld        = 1'b0;
        w_skid_ld        = 1'b0;
        w_main_from_skid = 1'b0;
        if (flush) begin
            w_main_vd = 1'b0;
            w_skid_vd = 1'b0;
        end else if (!w_main_v) begin
            if (w_accept) begin
                w_main_vd = 1'b1;
                w_main_ld = 1'b1;
            end
        end else if (!w_skid_v) begin
            if (w_accept && w_consume) begin
                w_main_ld = 1'b1;
            end else if (w_accept) begin
                w_skid_vd = 1'b1;
                w_skid_ld = 1'b1;
            end else if (w_consume) begin
                w_main_vd = 1'b0;
            end
        end else if (w_consume) begin
            w_skid_vd        = 1'b0;
            w_main_ld        = 1'b1;
            w_main_from_skid = 1'b1;
        end
    end

    alu_opstage_entry #(.XLEN(XLEN), .REG_AW(REG_AW)) u_main (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid_d  (w_main_vd),
        .i_load     (w_main_ld),
        .i_a        (w_main_from_skid ? w_skid_fa   : w_cap_a),
        .i_b        (w_main_from_skid ? w_skid_fb   : w_cap_b),
        .i_sel      (w_main_from_skid ? w_skid_sel  : alu_sel_in),
        .i_rd       (w_main_from_skid ? w_skid_rd   : rd_in),
        .i_wen      (w_main_from_skid ? w_skid_wen  : wen_in),
        .i_rs1_addr (w_main_from_skid ? w_skid_rs1  : rs1_addr),
        .i_rs2_addr (w_main_from_skid ? w_skid_rs2  : rs2_addr),
        .i_a_sel    (w_main_from_skid ? w_skid_asel : a_sel),
        .i_b_sel    (w_main_from_skid ? w_skid_bsel : b_sel),
        .i_wb_en    (wb_en),
        .i_wb_rd    (wb_rd),
        .i_wb_data  (wb_data),
        .o_valid    (w_main_v),
        .o_a        (alu_a),
        .o_b        (alu_b),
        .o_fa       (w_main_unused_fa),
        .o_fb       (w_main_unused_fb),
        .o_sel      (alu_sel),
        .o_rd       (rd_out),
        .o_wen      (wen_out),
        .o_rs1_addr (w_main_unused_rs1),
        .o_rs2_addr (w_main_unused_rs2),
        .o_a_sel    (w_main_unused_asel),
        .o_b_sel    (w_main_unused_bsel)
    );

    alu_opstage_entry #(.XLEN(XLEN), .REG_AW(REG_AW)) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid_d  (w_skid_vd),
        .i_load     (w_skid_ld),
        .i_a        (w_cap_a),
        .i_b        (w_cap_b),
        .i_sel      (alu_sel_in),
        .i_rd       (rd_in),
        .i_wen      (wen_in),
        .i_rs1_addr (rs1_addr),
        .i_rs2_addr (rs2_addr),
        .i_a_sel    (a_sel),
        .i_b_sel    (b_sel),
        .i_wb_en    (wb_en),
        .i_wb_rd    (wb_rd),
        .i_wb_data  (wb_data),
        .o_valid    (w_skid_v),
        .o_a        (w_skid_unused_a),
        .o_b        (w_skid_unused_b),
        .o_fa       (w_skid_fa),
        .o_fb       (w_skid_fb),
        .o_sel      (w_skid_sel),
        .o_rd       (w_skid_rd),
        .o_wen      (w_skid_wen),
        .o_rs1_addr (w_skid_rs1),
        .o_rs2_addr (w_skid_rs2),
        .o_a_sel    (w_skid_asel),
        .o_b_sel    (w_skid_bsel)
    );

endmodule

`default_nettype wire
